// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and register map for the debug run controller.
package cpu_run_ctrl_pkg;

    // Encoding matches STATUS[1:0] as seen by the host.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HALT_REQ = 2'd1,
        ST_HALTED   = 2'd2,
        ST_STEP     = 2'd3
    } run_state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STEP   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CYCLE  = 2'd3;

    localparam int CTRL_MODE_BIT  = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    localparam int STATUS_TIMEOUT_BIT   = 2;
    localparam int STATUS_STEP_ERR_BIT  = 3;
    localparam int STATUS_QUIESCED_BIT  = 4;
    localparam int STATUS_REMAINING_LSB = 16;

endpackage

// File: rtl/run_down_counter.sv
// Loadable 16-bit down-counter with a zero flag; load takes priority over decrement.
module run_down_counter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        dec,
    output logic [15:0] count,
    output logic        zero
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 16'd0;
        end else if (load) begin
            count <= load_value;
        end else if (dec) begin
            count <= count - 16'd1;
        end
    end

    assign zero = (count == 16'd0);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Avalon-MM run/halt/step controller producing a registered pipeline advance enable.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter bit          RESET_HALTED  = 1'b0,
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        cpu_quiesced,
    output logic        cpu_clk_en,
    output logic        halt_req,
    output logic        halted
);

    // Loaded one short so the zero flag marks the final HALT_REQ cycle.
    localparam logic [15:0] DRAIN_LOAD = 16'(DRAIN_TIMEOUT - 1);

    run_state_t  state;
    run_state_t  state_next;
    logic        mode;
    logic        timeout_flag;
    logic        step_err_flag;
    logic [31:0] cycle_count;

    logic        wr;
    logic        ctrl_wr;
    logic        step_wr;
    logic        cycle_wr;
    logic [15:0] step_n;

    logic        drain_load;
    logic        drain_dec;
    logic        drain_zero;
    logic [15:0] drain_count_unused;
    logic        step_load;
    logic [15:0] step_load_value;
    logic        step_dec;
    logic        step_zero;
    logic [15:0] remaining;
    logic        timeout_set;
    logic        step_err_set;

    assign wr       = chipselect && !write_n;
    assign ctrl_wr  = wr && (address == ADDR_CTRL);
    assign step_wr  = wr && (address == ADDR_STEP);
    assign cycle_wr = wr && (address == ADDR_CYCLE);
    assign step_n   = writedata[15:0];

    assign drain_dec = (state == ST_HALT_REQ) && !drain_zero;
    assign step_dec  = (state == ST_STEP) && !step_zero;

    run_down_counter u_drain_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (drain_load),
        .load_value (DRAIN_LOAD),
        .dec        (drain_dec),
        .count      (drain_count_unused),
        .zero       (drain_zero)
    );

    run_down_counter u_step_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (step_load),
        .load_value (step_load_value),
        .dec        (step_dec),
        .count      (remaining),
        .zero       (step_zero)
    );

    // A CTRL write is evaluated last so it overrides step completion and timeout.
    always_comb begin
        state_next      = state;
        drain_load      = 1'b0;
        step_load       = 1'b0;
        step_load_value = step_n;
        timeout_set     = 1'b0;
        step_err_set    = 1'b0;

        case (state)
            ST_RUN: begin
                if (step_wr) step_err_set = 1'b1;
            end
            ST_HALT_REQ: begin
                if (step_wr) step_err_set = 1'b1;
                if (cpu_quiesced) begin
                    state_next = ST_HALTED;
                end else if (drain_zero) begin
                    state_next  = ST_HALTED;
                    timeout_set = 1'b1;
                end
            end
            ST_HALTED: begin
                if (step_wr && (step_n != 16'd0)) begin
                    state_next = ST_STEP;
                    step_load  = 1'b1;
                end
            end
            ST_STEP: begin
                if (remaining == 16'd1) state_next = ST_HALTED;
            end
            default: state_next = ST_RUN;
        endcase

        if (ctrl_wr) begin
            if (!writedata[CTRL_MODE_BIT]) begin
                state_next      = ST_RUN;
                step_load       = 1'b1;
                step_load_value = 16'd0;
                timeout_set     = 1'b0;
            end else if (state == ST_RUN) begin
                state_next = ST_HALT_REQ;
                drain_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RESET_HALTED ? ST_HALTED : ST_RUN;
            cpu_clk_en <= !RESET_HALTED;
            halt_req   <= RESET_HALTED;
            halted     <= RESET_HALTED;
            mode       <= RESET_HALTED;
        end else begin
            state      <= state_next;
            cpu_clk_en <= (state_next != ST_HALTED);
            halt_req   <= (state_next != ST_RUN);
            halted     <= (state_next == ST_HALTED);
            if (ctrl_wr) mode <= writedata[CTRL_MODE_BIT];
        end
    end

    // Sticky flags: a new event in the same cycle beats the write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_flag  <= 1'b0;
            step_err_flag <= 1'b0;
        end else begin
            timeout_flag  <= (timeout_flag && !(ctrl_wr && writedata[CTRL_CLEAR_BIT])) || timeout_set;
            step_err_flag <= (step_err_flag && !(ctrl_wr && writedata[CTRL_CLEAR_BIT])) || step_err_set;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count <= 32'd0;
        end else if (cycle_wr) begin
            cycle_count <= 32'd0;
        end else if (cpu_clk_en) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_CTRL: readdata[CTRL_MODE_BIT] = mode;
            ADDR_STEP: readdata[15:0] = remaining;
            ADDR_STATUS: begin
                readdata[1:0]                                          = state;
                readdata[STATUS_TIMEOUT_BIT]                           = timeout_flag;
                readdata[STATUS_STEP_ERR_BIT]                          = step_err_flag;
                readdata[STATUS_QUIESCED_BIT]                          = cpu_quiesced;
                readdata[STATUS_REMAINING_LSB +: 16]                   = remaining;
            end
            default: readdata = cycle_count;
        endcase
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench: two controllers (reset running / reset halted) checked against a cycle model.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic        cpu_quiesced = 1'b0;

    logic [31:0] rd0, rd1;
    logic        en0, en1, hr0, hr1, h0, h1;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.RESET_HALTED(1'b0), .DRAIN_TIMEOUT(8)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .cpu_quiesced(cpu_quiesced), .cpu_clk_en(en0), .halt_req(hr0), .halted(h0)
    );

    cpu_run_ctrl #(.RESET_HALTED(1'b1), .DRAIN_TIMEOUT(5)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .cpu_quiesced(cpu_quiesced), .cpu_clk_en(en1), .halt_req(hr1), .halted(h1)
    );

    // Model phase codes: 0 running, 1 draining, 2 stopped, 3 stepping.
    typedef struct {
        int         st;
        bit         mode;
        int         drain;
        int         rem;
        bit         tmo;
        bit         serr;
        bit [31:0]  cyc;
    } model_t;

    typedef struct {
        int         inst;
        bit [31:0]  rd;
        bit         en;
        bit         hr;
        bit         h;
        string      tag;
    } exp_t;

    exp_t   sb[$];
    model_t m[2];
    int     drain_cfg[2] = '{8, 5};
    bit     rh_cfg[2]    = '{1'b0, 1'b1};
    int     total = 0;
    int     bad = 0;

    function automatic model_t resetModel(bit rh);
        model_t s;
        s.st = rh ? 2 : 0;
        s.mode = rh;
        s.drain = 0;
        s.rem = 0;
        s.tmo = 0;
        s.serr = 0;
        s.cyc = 0;
        return s;
    endfunction

    function automatic bit [31:0] readModel(model_t s, bit [1:0] a, bit q);
        case (a)
            2'd0: return {31'b0, s.mode};
            2'd1: return {16'b0, 16'(s.rem)};
            2'd2: return {16'(s.rem), 11'b0, q, s.serr, s.tmo, 2'(s.st)};
            default: return s.cyc;
        endcase
    endfunction

    function automatic model_t stepModel(model_t s, int dcfg, bit wr, bit [1:0] a, bit [31:0] wd, bit q);
        model_t n = s;
        n.cyc = (wr && a == 2'd3) ? 32'd0 : s.cyc + ((s.st != 2) ? 32'd1 : 32'd0);
        if (wr && a == 2'd0 && wd[1]) begin
            n.tmo = 0;
            n.serr = 0;
        end
        if (wr && a == 2'd1 && (s.st == 0 || s.st == 1)) n.serr = 1;
        case (s.st)
            1: begin
                if (q) n.st = 2;
                else begin
                    n.drain = s.drain - 1;
                    if (n.drain == 0) begin
                        n.st = 2;
                        n.tmo = 1;
                    end
                end
            end
            2: if (wr && a == 2'd1 && wd[15:0] != 16'd0) begin
                n.st = 3;
                n.rem = int'(wd[15:0]);
            end
            3: begin
                n.rem = s.rem - 1;
                if (n.rem == 0) n.st = 2;
            end
            default: ;
        endcase
        if (wr && a == 2'd0) begin
            n.mode = wd[0];
            if (!wd[0]) begin
                n.st = 0;
                n.rem = 0;
                n.tmo = wd[1] ? 1'b0 : s.tmo;
            end else if (s.st == 0) begin
                n.st = 1;
                n.drain = dcfg;
            end
        end
        return n;
    endfunction

    // Drive one cycle at the falling edge and queue what both controllers must show.
    task automatic applyStimulus(input bit rst, input bit cs, input bit wn, input bit [1:0] a,
                                 input bit [31:0] wd, input bit q, input string tag);
        exp_t e;
        @(negedge clk);
        reset_n = !rst;
        chipselect = cs;
        write_n = wn;
        address = a;
        writedata = wd;
        cpu_quiesced = q;
        for (int i = 0; i < 2; i++) begin
            if (rst) m[i] = resetModel(rh_cfg[i]);
            e.inst = i;
            e.rd = readModel(m[i], a, q);
            e.en = (m[i].st != 2);
            e.hr = (m[i].st != 0);
            e.h = (m[i].st == 2);
            e.tag = tag;
            sb.push_back(e);
            if (!rst) m[i] = stepModel(m[i], drain_cfg[i], cs && !wn, a, wd, q);
        end
    endtask

    task automatic cmpField(input string tag, input string what, input int inst,
                            input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s/%s inst%0d got=%h want=%h", tag, what, inst, got, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        if (e.inst == 0) begin
            cmpField(e.tag, "readdata", 0, rd0, e.rd);
            cmpField(e.tag, "cpu_clk_en", 0, {31'b0, en0}, {31'b0, e.en});
            cmpField(e.tag, "halt_req", 0, {31'b0, hr0}, {31'b0, e.hr});
            cmpField(e.tag, "halted", 0, {31'b0, h0}, {31'b0, e.h});
        end else begin
            cmpField(e.tag, "readdata", 1, rd1, e.rd);
            cmpField(e.tag, "cpu_clk_en", 1, {31'b0, en1}, {31'b0, e.en});
            cmpField(e.tag, "halt_req", 1, {31'b0, hr1}, {31'b0, e.hr});
            cmpField(e.tag, "halted", 1, {31'b0, h1}, {31'b0, e.h});
        end
    endtask

    // Monitor: drains whatever the driver queued for this cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) checkOutput(sb.pop_front());
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    task automatic idle(input int n, input bit q, input string tag);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b1, 1'b1, 2'($urandom_range(0, 3)), 32'd0, q, tag);
    endtask

    task automatic wr(input bit [1:0] a, input bit [31:0] wd, input bit q, input string tag);
        applyStimulus(1'b0, 1'b1, 1'b0, a, wd, q, tag);
    endtask

    initial begin
        m[0] = resetModel(1'b0);
        m[1] = resetModel(1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 32'd0, 1'b0, "reset");
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 32'd0, 1'b0, "reset");
        idle(10, 1'b0, "idle");
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd3, 32'd0, 1'b0, "cycle10");

        wr(2'd0, 32'd1, 1'b0, "halt_q");
        idle(4, 1'b0, "drain");
        idle(4, 1'b1, "quiesced");
        wr(2'd0, 32'd0, 1'b1, "resume");
        idle(2, 1'b0, "run");

        wr(2'd0, 32'd1, 1'b0, "halt_to");
        idle(12, 1'b0, "timeout");
        wr(2'd0, 32'd3, 1'b0, "clr_to");
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 32'd0, 1'b0, "status");

        wr(2'd1, 32'd3, 1'b0, "step3");
        idle(5, 1'b0, "stepping");
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 32'd0, 1'b0, "status");

        wr(2'd0, 32'd0, 1'b0, "run");
        wr(2'd1, 32'd5, 1'b0, "step_err");
        idle(2, 1'b0, "err");
        wr(2'd0, 32'd3, 1'b1, "halt_clr");
        idle(3, 1'b1, "halting");
        wr(2'd1, 32'd100, 1'b0, "step100");
        idle(4, 1'b0, "step_long");
        wr(2'd0, 32'd0, 1'b0, "abort_step");
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 32'd0, 1'b0, "remaining");
        idle(2, 1'b0, "run");

        wr(2'd0, 32'd1, 1'b1, "halt");
        idle(3, 1'b1, "halting");
        wr(2'd1, 32'd20, 1'b0, "step20");
        idle(3, 1'b0, "mid_step");
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd2, 32'd0, 1'b0, "reset_mid");
        idle(2, 1'b0, "post_reset");
        wr(2'd0, 32'd1, 1'b1, "halt");
        idle(3, 1'b1, "halting");
        wr(2'd1, 32'd0, 1'b0, "step0");
        idle(3, 1'b0, "step0_idle");

        wr(2'd0, 32'd0, 1'b0, "run");
        idle(3, 1'b0, "run");
        wr(2'd3, 32'hFFFF_FFFF, 1'b0, "cycle_clr");
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd3, 32'd0, 1'b0, "cycle_read");
        wr(2'd2, 32'hFFFF_FFFF, 1'b0, "status_wr");

        for (int k = 0; k < 3000; k++) begin
            bit        rst;
            bit        cs;
            bit        wn;
            bit [1:0]  a;
            bit [31:0] wd;
            bit        q;
            rst = ($urandom_range(0, 299) == 0);
            cs  = ($urandom_range(0, 3) != 0);
            wn  = ($urandom_range(0, 4) != 0);
            a   = 2'($urandom_range(0, 3));
            wd  = $urandom;
            if (a == 2'd1) wd[15:0] = 16'($urandom_range(0, 10));
            q   = ($urandom_range(0, 5) == 0);
            applyStimulus(rst, cs, wn, a, wd, q, "rand");
        end

        idle(2, 1'b0, "tail");
        @(negedge clk);
        #5;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Avalon-MM debug controller that schedules when the RV32IM pipeline clock advances in the debug SoC. It turns host software commands (run, halt, step N cycles) into a single registered clock-enable `cpu_clk_en` plus a halt handshake with the pipeline. The pipeline keeps running on `clk` and uses `cpu_clk_en` as its enable, so no clock gating or clock muxing happens in fabric. A cycle counter and a status register give the host visibility.

## Interface
- `RESET_HALTED`, default 0: 1 means the block leaves reset in HALTED, 0 means RUN.
- `DRAIN_TIMEOUT`, default 64: maximum number of cycles spent in HALT_REQ waiting for `cpu_quiesced`; range 1..65535.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  register select: 0 CTRL, 1 STEP, 2 STATUS, 3 CYCLE.
- `chipselect`  in  1  Avalon slave select.
- `write_n`  in  1  active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata`  in  32  write data.
- `readdata`  out  32  combinational read of the register at `address`; zero wait states.
- `cpu_quiesced`  in  1  pipeline reports it is drained and safe to stop.
- `cpu_clk_en`  out  1  registered pipeline advance enable.
- `halt_req`  out  1  registered request for the pipeline to drain.
- `halted`  out  1  registered; high in HALTED only.

## Operation
FSM states: RUN, HALT_REQ, HALTED, STEP.

- **RUN**
  - `cpu_clk_en`=1, `halt_req`=0.
  - Write CTRL with bit0=1 -> HALT_REQ.
- **HALT_REQ**
  - `cpu_clk_en`=1, `halt_req`=1. The drain timer loads `DRAIN_TIMEOUT` on entry.
  - `cpu_quiesced`=1 -> HALTED.
  - Timer reaches 0 -> HALTED, and sticky `TIMEOUT` is set.
  - Write CTRL with bit0=0 -> RUN (halt cancelled).
- **HALTED**
  - `cpu_clk_en`=0, `halt_req`=1, `halted`=1.
  - Write STEP with N=`writedata[15:0]`, N≠0 -> STEP, with `remaining`=N.
  - Write CTRL with bit0=0 -> RUN.
- **STEP**
  - `cpu_clk_en`=1, `halt_req`=1. `remaining` decrements on every cycle.
  - On the cycle `remaining`=1 -> HALTED.
  - Write CTRL with bit0=0 -> RUN and `remaining` clears to 0.
  - Writes to STEP are ignored here.

Writes that change nothing:
- STEP write with N=0 has no effect.
- STEP write in RUN or HALT_REQ is ignored and sets sticky `STEP_ERR`.

Registers:
- **CTRL** (read/write)
  - bit0 `mode`: 0=run, 1=halt.
  - bit1 is write-1-to-clear for both `TIMEOUT` and `STEP_ERR`.
  - Reads return `mode` in bit0; all other bits read 0.
- **STEP**
  - Reads return `{16'b0, remaining}`.
- **STATUS** (read-only)
  - [1:0] state encoding: RUN=0, HALT_REQ=1, HALTED=2, STEP=3.
  - [2] `TIMEOUT`, [3] `STEP_ERR`, [4] `cpu_quiesced`.
  - [31:16] `remaining`.
  - Writes to STATUS are ignored.
- **CYCLE**
  - 32-bit count of cycles with `cpu_clk_en`=1.
  - Wraps from 0xFFFFFFFF to 0.
  - Any write clears it to 0. If the write lands on an enabled cycle, the result is 0, not 1.

## Timing
- Reset values:
  - `RESET_HALTED`=0: RUN, `cpu_clk_en`=1, `halt_req`=0, `halted`=0, `mode`=0.
  - `RESET_HALTED`=1: HALTED, `cpu_clk_en`=0, `halt_req`=1, `halted`=1, `mode`=1.
  - In both cases `remaining`=0, CYCLE=0, and both sticky flags are 0.
- All outputs are registered and change on the clk edge that commits the state transition.
  - A write on cycle t affects the outputs from cycle t+1.
  - STEP N written at t gives `cpu_clk_en`=1 for cycles t+1..t+N, then 0 at t+N+1.
- `cpu_quiesced` is sampled each cycle in HALT_REQ only. If it is already high on the first HALT_REQ cycle, HALTED is reached 2 cycles after the CTRL write.
- Timeout: exactly `DRAIN_TIMEOUT` HALT_REQ cycles, then HALTED.
- CTRL `mode` and the state update on the same edge. A CTRL write always wins over a step ending or a timeout on the same cycle.
- Asserting `reset_n` mid-STEP or mid-HALT_REQ aborts immediately to the reset state; there is no partial step.

## Structure
- Package `cpu_run_ctrl_pkg` holds:
  - the state enum (2-bit encoding as in STATUS);
  - register address constants;
  - STATUS and CTRL bit-position constants.
- One sub-module, `run_down_counter`: a loadable 16-bit down-counter with a zero flag. It is instantiated twice, once for the drain timer and once for the step counter.

## Test plan
- Reset with `RESET_HALTED`=0, idle 10 cycles -> `cpu_clk_en`=1 throughout, CYCLE reads 10 (±1 depending on the read cycle), STATUS[1:0]=0.
- Write CTRL=1 with `cpu_quiesced` raised 5 cycles later -> HALT_REQ for 5 cycles, then `halted`=1, `cpu_clk_en`=0, `TIMEOUT`=0.
- With `DRAIN_TIMEOUT`=8 and `cpu_quiesced` held 0, write CTRL=1 -> HALTED after 8 HALT_REQ cycles, STATUS[2]=1; writing CTRL=3 clears the flag and keeps halt.
- In HALTED, write STEP=3 -> `cpu_clk_en` high for exactly 3 cycles, CYCLE increments by 3, back to HALTED, STATUS[31:16]=0.
- In RUN, write STEP=5 -> ignored, STATUS[3]=1. In STEP with 100 remaining, write CTRL=0 -> RUN on the next cycle with `remaining`=0.
- Assert `reset_n` mid-STEP, and write STEP=0 in HALTED -> reset state is restored with `remaining`=0; the STEP=0 write leaves the block in HALTED with no enable pulse.
